// File: rtl/rr_arbiter.sv
// Registered N-way arbiter with fixed or round-robin priority and optional grant blocking.
// Optional grant watchdog is enabled by defining ARB_GRANT_TIMEOUT_EN.

module rr_arbiter_priority_encoder #(
  parameter int WIDTH    = 4,
  parameter int LSB_HIGH = 1,
  parameter int IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    if (LSB_HIGH != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i]) idx = IW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req[i]) idx = IW'(i);
      end
    end
  end

endmodule

module rr_arbiter #(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int ARB_BLOCK             = 1,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1,
  parameter int TIMEOUT_CYCLES        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded,
  output logic                     grant_timeout
);

  localparam int IW = $clog2(PORTS);

  logic [PORTS-1:0] grant_q, grant_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic [IW-1:0]    enc_q, enc_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;

  logic             m_valid, r_valid;
  logic [IW-1:0]    m_idx, r_idx;
  logic             hold_raw, hold, tmo_hit;
  logic             take;
  logic [IW-1:0]    new_idx;

  rr_arbiter_priority_encoder #(
    .WIDTH(PORTS), .LSB_HIGH(ARB_LSB_HIGH_PRIORITY), .IW(IW)
  ) u_enc_masked (
    .req(request & mask_q), .valid(m_valid), .idx(m_idx)
  );

  rr_arbiter_priority_encoder #(
    .WIDTH(PORTS), .LSB_HIGH(ARB_LSB_HIGH_PRIORITY), .IW(IW)
  ) u_enc_raw (
    .req(request), .valid(r_valid), .idx(r_idx)
  );

  always_comb begin
    hold_raw = 1'b0;
    if (ARB_BLOCK != 0) begin
      if (ARB_BLOCK_ACK != 0) hold_raw = valid_q && !acknowledge[enc_q];
      else                    hold_raw = valid_q && request[enc_q];
    end
  end

`ifdef ARB_GRANT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Count holds past the grant edge; the grant is visible for TIMEOUT_CYCLES cycles at most.
  assign tmo_hit = hold_raw && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d   = hold ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign hold = hold_raw && !tmo_hit;

  // Release and re-arbitration share a cycle, so handover has no bubble.
  always_comb begin
    grant_d = grant_q;
    enc_d   = enc_q;
    valid_d = valid_q;
    mask_d  = mask_q;
    tmo_d   = tmo_hit;
    take    = 1'b0;
    new_idx = '0;
    if (!hold) begin
      grant_d = '0;
      enc_d   = '0;
      valid_d = 1'b0;
      if ((ARB_TYPE_ROUND_ROBIN != 0) && m_valid) begin
        take    = 1'b1;
        new_idx = m_idx;
      end else if (r_valid) begin
        take    = 1'b1;
        new_idx = r_idx;
      end
      if (take) begin
        grant_d = PORTS'(1) << new_idx;
        enc_d   = new_idx;
        valid_d = 1'b1;
        if (ARB_TYPE_ROUND_ROBIN != 0) begin
          for (int i = 0; i < PORTS; i++) begin
            if (ARB_LSB_HIGH_PRIORITY != 0) mask_d[i] = (i > int'(new_idx));
            else                            mask_d[i] = (i < int'(new_idx));
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q <= '0;
      enc_q   <= '0;
      valid_q <= 1'b0;
      mask_q  <= '1;
      tmo_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      enc_q   <= enc_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = valid_q;
  assign grant_encoded = enc_q;
  assign grant_timeout = tmo_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed-vector bench for rr_arbiter: default round-robin/ack-blocking instance
// plus two fixed-priority, non-blocking instances (LSB-high and MSB-high).

module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] request;
  logic [3:0] acknowledge;

  logic [3:0] g0, g1, g2;
  logic       v0, v1, v2;
  logic [1:0] e0, e1, e2;
  logic       t0, t1, t2;

  int n_vec  = 0;
  int n_fail = 0;

  rr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .grant(g0), .grant_valid(v0), .grant_encoded(e0), .grant_timeout(t0)
  );

  rr_arbiter #(.ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_LSB_HIGH_PRIORITY(1)) dut_fix_lsb (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .grant(g1), .grant_valid(v1), .grant_encoded(e1), .grant_timeout(t1)
  );

  rr_arbiter #(.ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_LSB_HIGH_PRIORITY(0)) dut_fix_msb (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .grant(g2), .grant_valid(v2), .grant_encoded(e2), .grant_timeout(t2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change #1 after the rising edge, outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] ack);
    request     = req;
    acknowledge = ack;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [3:0] exp_g, input logic [1:0] exp_e);
    check_val({tag, ".grant"}, 32'(g0), 32'(exp_g));
    check_val({tag, ".valid"}, 32'(v0), 32'(exp_g != 4'b0));
    check_val({tag, ".enc"},   32'(e0), 32'(exp_e));
  endtask

  // Expected round-robin grant sequence with acknowledge every cycle
  logic [3:0] rr_seq [5];
  logic [1:0] rr_enc [5];

  initial begin
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
    rr_enc[0] = 2'd0; rr_enc[1] = 2'd1; rr_enc[2] = 2'd2;
    rr_enc[3] = 2'd3; rr_enc[4] = 2'd0;

    rst_n = 1'b0;
    drive(4'b1111, 4'b0000);

    // Reset held two cycles with every port requesting
    for (int i = 0; i < 2; i++) begin
      step();
      check_main($sformatf("reset%0d", i), 4'b0000, 2'd0);
      check_val("reset.tmo", 32'(t0), 32'd0);
    end

    // Round-robin rotation with ack on the granted port every cycle
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_main($sformatf("rr%0d", i), rr_seq[i], rr_enc[i]);
      drive(4'b1111, rr_seq[i]);
    end

    // Move grant to port 2, then drop its request without ack
    drive(4'b0100, 4'b0001);
    step();
    check_main("to_p2", 4'b0100, 2'd2);
    drive(4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check_main($sformatf("hold_p2_%0d", i), 4'b0100, 2'd2);
    end
    drive(4'b0010, 4'b0010);
    step();
    check_main("ack1_ignored", 4'b0100, 2'd2);
    drive(4'b0010, 4'b0100);
    step();
    check_main("ack2_release", 4'b0010, 2'd1);

    // Wrap: port 3 granted, then ack with 1001 in the same cycle
    drive(4'b1000, 4'b0010);
    step();
    check_main("to_p3", 4'b1000, 2'd3);
    drive(4'b1001, 4'b1000);
    step();
    check_main("wrap_p0", 4'b0001, 2'd0);
    drive(4'b1000, 4'b0001);
    step();
    check_main("to_p3_again", 4'b1000, 2'd3);
    drive(4'b1000, 4'b1000);
    step();
    check_main("sole_regrant", 4'b1000, 2'd3);

    // Release with nothing pending goes idle
    drive(4'b0000, 4'b1000);
    step();
    check_main("idle", 4'b0000, 2'd0);

    // Reset mid-grant drops the grant regardless of hold
    drive(4'b0001, 4'b0000);
    step();
    check_main("pre_rst", 4'b0001, 2'd0);
    rst_n = 1'b0;
    step();
    check_main("mid_rst", 4'b0000, 2'd0);
    rst_n = 1'b1;

    // Watchdog behaviour with two requesters and no ack
    drive(4'b0011, 4'b0000);
`ifdef ARB_GRANT_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      step();
      check_main($sformatf("wd_hold%0d", i), 4'b0001, 2'd0);
      check_val("wd_hold.tmo", 32'(t0), 32'd0);
    end
    step();
    check_main("wd_release", 4'b0010, 2'd1);
    check_val("wd_pulse", 32'(t0), 32'd1);
    step();
    check_main("wd_after", 4'b0010, 2'd1);
    check_val("wd_after.tmo", 32'(t0), 32'd0);
`else
    for (int i = 0; i < 24; i++) begin
      step();
      check_main($sformatf("nowd%0d", i), 4'b0001, 2'd0);
      check_val("nowd.tmo", 32'(t0), 32'd0);
    end
`endif

    // Fixed priority, no blocking, request 1010
    drive(4'b1010, 4'b0000);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("fix_lsb%0d.grant", i), 32'(g1), 32'h2);
      check_val($sformatf("fix_lsb%0d.enc", i),   32'(e1), 32'd1);
      check_val($sformatf("fix_msb%0d.grant", i), 32'(g2), 32'h8);
      check_val($sformatf("fix_msb%0d.enc", i),   32'(e2), 32'd3);
    end
    check_val("fix.valid", 32'({v1, v2}), 32'h3);

    // Fixed priority follows request changes every cycle
    drive(4'b0110, 4'b0000);
    step();
    check_val("fix_lsb_chg", 32'(g1), 32'h2);
    check_val("fix_msb_chg", 32'(g2), 32'h4);
    drive(4'b0000, 4'b0000);
    step();
    check_val("fix_idle", 32'({g1, g2}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
